// File: rtl/serial_sub_if.sv
// Start/done handshake and operand/result bundle for serial_sub.
// master = controller side, slave = the subtractor.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Do;
  logic             Bo;

  modport master (
    output start, a, b, bin,
    input  busy, done, Do, Bo
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, Do, Bo
  );
endinterface

// File: rtl/serial_sub.sv
// Digit-serial subtractor: WIDTH-bit a - b - bin, DIGIT bits per cycle LSB-first,
// borrow carried between cycles, result published with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; Do/Bo hold the last result
// RUN   | one digit per cycle, cnt = index of digit being processed
module serial_sub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic         clk,
  input logic         rst_n,
  serial_sub_if.slave bus
);
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]       a_sh;
  logic [WIDTH-1:0]       b_sh;
  logic [WIDTH-1:0]       res;
  logic [CNT_W-1:0]       cnt;
  logic                   borrow;
  logic [WIDTH-1:0]       do_q;
  logic                   bo_q;
  logic                   done_q;
  logic [DIGIT:0]         dig;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0]       res_nxt;
  logic                   last;
  logic                   unused_shifted_out;

  // One digit step: {borrow_out, diff} = a_d - b_d - borrow_in, all unsigned.
  assign dig = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow};

  // New digit enters at the MSB end; after N steps the first digit sits at bit 0.
  assign res_cat            = {dig[DIGIT-1:0], res} >> DIGIT;
  assign res_nxt            = res_cat[WIDTH-1:0];
  assign unused_shifted_out = ^res_cat[WIDTH+DIGIT-1:WIDTH];

  assign last = (cnt == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      do_q   <= '0;
      bo_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_sh   <= bus.a;
          b_sh   <= bus.b;
          borrow <= bus.bin;
          cnt    <= '0;
        end
      end else begin
        a_sh   <= a_sh >> DIGIT;
        b_sh   <= b_sh >> DIGIT;
        borrow <= dig[DIGIT];
        res    <= res_nxt;
        cnt    <= cnt + 1'b1;
        // Only the completed result is ever exposed on Do/Bo.
        if (last) begin
          do_q   <= res_nxt;
          bo_q   <= dig[DIGIT];
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.Do   = do_q;
  assign bus.Bo   = bo_q;
endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed handshake cases and random ops on an
// 8-bit/1-digit instance, plus an exhaustive 4-bit sweep across DIGIT = 1, 2, 4.
module tb_serial_sub;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8)) m8 ();
  serial_sub_if #(.WIDTH(4)) s1 ();
  serial_sub_if #(.WIDTH(4)) s2 ();
  serial_sub_if #(.WIDTH(4)) s4 ();

  serial_sub #(.WIDTH(8), .DIGIT(1)) dut8  (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
  serial_sub #(.WIDTH(4), .DIGIT(1)) dut41 (.clk(clk), .rst_n(rst_n), .bus(s1.slave));
  serial_sub #(.WIDTH(4), .DIGIT(2)) dut42 (.clk(clk), .rst_n(rst_n), .bus(s2.slave));
  serial_sub #(.WIDTH(4), .DIGIT(4)) dut44 (.clk(clk), .rst_n(rst_n), .bus(s4.slave));

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt8 = 0;
  logic [7:0] exp_do8 = 8'h00;
  logic       exp_bo8 = 1'b0;

  always @(negedge clk) if (m8.done === 1'b1) done_cnt8++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic void ref_sub(input int w, input int a, input int b, input int bin,
                                  output int d, output int bo);
    d  = (a - b - bin) & ((1 << w) - 1);
    bo = (a < b + bin) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit op; returns positioned #1 after the edge where done rose.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin, input string tag);
    int d, bo, lat;
    ref_sub(8, int'(a), int'(b), int'(bin), d, bo);
    m8.a = a; m8.b = b; m8.bin = bin; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    m8.a = 8'($urandom); m8.b = 8'($urandom); m8.bin = 1'($urandom);
    lat = 0;
    while (m8.done !== 1'b1 && lat < 20) begin
      check({tag, "_busy"}, 32'(m8.busy), 32'(1));
      check({tag, "_hold_do"}, 32'(m8.Do), 32'(exp_do8));
      check({tag, "_hold_bo"}, 32'(m8.Bo), 32'(exp_bo8));
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(8));
    check({tag, "_busy_end"}, 32'(m8.busy), 32'(0));
    check({tag, "_do"}, 32'(m8.Do), 32'(d));
    check({tag, "_bo"}, 32'(m8.Bo), 32'(bo));
    exp_do8 = 8'(d);
    exp_bo8 = 1'(bo);
  endtask

  initial begin
    int dc0, lat, d, bo;
    int lat1, lat2, lat4;
    time t_first;
    m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.bin = 1'b0;
    s1.start = 1'b0; s1.a = '0; s1.b = '0; s1.bin = 1'b0;
    s2.start = 1'b0; s2.a = '0; s2.b = '0; s2.bin = 1'b0;
    s4.start = 1'b0; s4.a = '0; s4.b = '0; s4.bin = 1'b0;

    // Reset state, with start held high to show it is ignored under reset.
    m8.start = 1'b1;
    #12;
    check("rst_busy", 32'(m8.busy), 32'(0));
    check("rst_done", 32'(m8.done), 32'(0));
    check("rst_do", 32'(m8.Do), 32'(0));
    check("rst_bo", 32'(m8.Bo), 32'(0));
    m8.start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(m8.busy), 32'(0));

    // Basic case and borrow boundaries.
    run8(8'h05, 8'h03, 1'b0, "basic");
    tick();
    check("basic_done_1cyc", 32'(m8.done), 32'(0));
    run8(8'h03, 8'h05, 1'b0, "neg");
    tick();
    run8(8'h00, 8'h00, 1'b1, "bin_only");
    tick();
    run8(8'hFF, 8'hFF, 1'b0, "equal");
    tick();

    // Hold-off: start during RUN must be ignored.
    dc0 = done_cnt8;
    m8.a = 8'h10; m8.b = 8'h01; m8.bin = 1'b0; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    tick();
    tick();
    m8.start = 1'b1; m8.a = 8'hAA; m8.b = 8'h55;
    for (int i = 0; i < 3; i++) begin
      check("holdoff_busy", 32'(m8.busy), 32'(1));
      tick();
    end
    m8.start = 1'b0;
    lat = 0;
    while (m8.done !== 1'b1 && lat < 20) begin
      check("holdoff_prev_do", 32'(m8.Do), 32'(exp_do8));
      tick();
      lat++;
    end
    check("holdoff_do", 32'(m8.Do), 32'(8'h0F));
    check("holdoff_bo", 32'(m8.Bo), 32'(0));
    exp_do8 = 8'h0F; exp_bo8 = 1'b0;
    tick();
    tick();
    check("holdoff_one_done", 32'(done_cnt8 - dc0), 32'(1));
    check("holdoff_idle", 32'(m8.busy), 32'(0));

    // Reset mid-operation.
    dc0 = done_cnt8;
    m8.a = 8'h80; m8.b = 8'h01; m8.bin = 1'b0; m8.start = 1'b1;
    tick();
    m8.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(m8.busy), 32'(0));
    check("abort_do", 32'(m8.Do), 32'(0));
    check("abort_bo", 32'(m8.Bo), 32'(0));
    tick();
    rst_n = 1'b1;
    exp_do8 = 8'h00; exp_bo8 = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("abort_no_done", 32'(done_cnt8 - dc0), 32'(0));
    check("abort_do_after", 32'(m8.Do), 32'(0));
    run8(8'h09, 8'h04, 1'b0, "post_abort");
    tick();

    // Back-to-back: second start issued in the done cycle.
    run8(8'h40, 8'h41, 1'b1, "b2b_first");
    t_first = $time;
    run8(8'h37, 8'h12, 1'b1, "b2b_second");
    check("b2b_spacing", 32'($time - t_first), 32'(90));

    // Random ops, random idle gaps (0 = back-to-back).
    for (int i = 0; i < 40; i++) begin
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
    end

    // Exhaustive 4-bit sweep; all three widths launched together.
    tick();
    for (int v = 0; v < 512; v++) begin
      ref_sub(4, v & 15, (v >> 4) & 15, (v >> 8) & 1, d, bo);
      s1.a = 4'(v); s1.b = 4'(v >> 4); s1.bin = 1'(v >> 8); s1.start = 1'b1;
      s2.a = 4'(v); s2.b = 4'(v >> 4); s2.bin = 1'(v >> 8); s2.start = 1'b1;
      s4.a = 4'(v); s4.b = 4'(v >> 4); s4.bin = 1'(v >> 8); s4.start = 1'b1;
      tick();
      s1.start = 1'b0; s2.start = 1'b0; s4.start = 1'b0;
      lat1 = -1; lat2 = -1; lat4 = -1;
      for (int c = 1; c <= 4; c++) begin
        tick();
        if (s1.done === 1'b1 && lat1 < 0) lat1 = c;
        if (s2.done === 1'b1 && lat2 < 0) lat2 = c;
        if (s4.done === 1'b1 && lat4 < 0) lat4 = c;
      end
      check("sw_d1_lat", 32'(lat1), 32'(4));
      check("sw_d2_lat", 32'(lat2), 32'(2));
      check("sw_d4_lat", 32'(lat4), 32'(1));
      check("sw_d1_do", 32'(s1.Do), 32'(d));
      check("sw_d1_bo", 32'(s1.Bo), 32'(bo));
      check("sw_d2_do", 32'(s2.Do), 32'(d));
      check("sw_d2_bo", 32'(s2.Bo), 32'(bo));
      check("sw_d4_do", 32'(s4.Do), 32'(d));
      check("sw_d4_bo", 32'(s4.Bo), 32'(bo));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor, the sequential successor to the single-bit half subtractor. It computes a WIDTH-bit difference with borrow-in, processing DIGIT bits per clock, LSB-first, and carries the borrow across cycles. It sits in the arithmetic datapath wherever area matters more than latency. A start/done handshake lets a controller launch one operation and collect the result.

## Interface
- WIDTH, 8: operand and difference width in bits; WIDTH >= 1.
- DIGIT, 1: bits processed per cycle; 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0.
- N (localparam) = WIDTH/DIGIT: number of compute cycles.
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to launch an operation; sampled only when busy=0.
- a  in  WIDTH  minuend, unsigned; captured when start is accepted.
- b  in  WIDTH  subtrahend, unsigned; captured when start is accepted.
- bin  in  1  borrow-in; captured when start is accepted.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when Do/Bo hold a new result.
- Do  out  WIDTH  difference, (a - b - bin) mod 2^WIDTH.
- Bo  out  1  borrow-out; 1 iff a < b + bin (unsigned).

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1. An internal digit counter runs from 0 to N-1.
- IDLE to RUN: on an edge where start=1.
  - Latch a, b and bin into internal shift registers.
  - Clear the counter.
  - Load the internal borrow with bin.
- In RUN, each cycle:
  - Take the low DIGIT bits of the shifted a and b, plus the current borrow.
  - Produce DIGIT difference bits and a new borrow.
  - Shift the difference bits into the result register from the MSB side.
  - Shift the a and b registers right by DIGIT.
  - Increment the counter.
- RUN to IDLE: on the edge that processes digit N-1.
  - Transfer the full result to Do and the final borrow to Bo.
  - Assert done for exactly one cycle.
- Outputs:
  - Do and Bo change only on completion.
  - They hold the previous result through IDLE and through the next RUN; they are not cleared at start.
  - Intermediate partial results are never visible on Do.
- start while busy=1 is ignored: no queueing, no effect on the current operation.
- Input changes after acceptance have no effect on the current operation.
- Arithmetic:
  - Each digit step is an unsigned (DIGIT+1)-bit subtract: {borrow_out, diff} = {1'b0, a_d} - {1'b0, b_d} - borrow_in.
  - No signed interpretation. Overflow is reported only through Bo.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state=IDLE, busy=0, done=0, Do=0, Bo=0.
  - Internal registers and counter = 0.
- Reset release is synchronous in effect: the first start is sampled on the first rising edge with rst_n=1.
- Reset mid-operation aborts the operation. No done pulse occurs, and Do/Bo read 0.
- Latency:
  - start is accepted at edge k, and busy=1 after edge k.
  - Result and done=1 appear after edge k+N.
  - busy=0 after edge k+N, at the same edge done rises.
- Throughput: a new start may be accepted at edge k+N+1, while done=1 is showing. This gives one operation per N+1 cycles maximum.
- DIGIT=WIDTH (N=1): result after edge k+1, i.e. single-cycle compute plus the capture cycle.
- done is never high for two consecutive cycles.

## Test plan
- WIDTH=8, DIGIT=1: a=8'h05, b=8'h03, bin=0, pulse start.
  - Expect busy for 8 cycles, then Do=8'h02, Bo=0, done high exactly 1 cycle, 8 cycles after acceptance.
- WIDTH=8, DIGIT=1, borrow boundaries:
  - a=8'h03, b=8'h05, bin=0 -> Do=8'hFE, Bo=1.
  - a=8'h00, b=8'h00, bin=1 -> Do=8'hFF, Bo=1.
  - a=8'hFF, b=8'hFF, bin=0 -> Do=8'h00, Bo=0.
- Hold-off: start a=8'h10, b=8'h01. At cycle 3, assert start with a=8'hAA, b=8'h55 and also change the a/b inputs.
  - Expect Do=8'h0F, Bo=0, and only one done.
  - Previous Do must stay stable until completion.
- Reset mid-operation: start a=8'h80, b=8'h01, then pull rst_n low for 1 cycle at cycle 3.
  - Expect busy=0, done never asserted, Do=0, Bo=0.
  - A following start with a=8'h09, b=8'h04 gives Do=8'h05.
- Back-to-back: assert start in the cycle done=1.
  - Expect acceptance, a second done exactly N+1 cycles after the first, and correct second result.
- Exhaustive sweep: WIDTH=4 with DIGIT in {1, 2, 4}, all 512 (a, b, bin) combinations.
  - Compare Do/Bo against (a - b - bin) mod 16 and a < b + bin, with done latency N each time.
